// File: rtl/booth_divider.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor, restoring division on magnitudes.
// Optional macro BOOTH_DIVIDER_DBZ_FAST_EN: a zero divisor skips the iterations and commits immediately.
module booth_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           ovf,
    output logic           dbz,
    output logic [1:0]     dbg_state_o
);
    localparam int CW = $clog2(2*N);
    localparam logic [2*N-1:0] LIM_POS = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic [2*N-1:0] LIM_NEG = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           sign_q_q, sign_q_d, sign_r_q, sign_r_d, zdiv_q, zdiv_d;
    logic [2*N-1:0] work_q, work_d;
    logic [N:0]     dvs_q, dvs_d, prem_q, prem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   quo_q, quo_d, rem_q, rem_d;
    logic           done_q, done_d, ovf_q, ovf_d, dbz_q, dbz_d;

    logic [N+1:0]   shifted, trial;
    logic [2*N-1:0] dvd_mag;
    logic [N-1:0]   dvs_mag, q_sgn, r_sgn;
    logic           q_big;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            zdiv_q   <= 1'b0;
            work_q   <= '0;
            dvs_q    <= '0;
            prem_q   <= '0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            zdiv_q   <= zdiv_d;
            work_q   <= work_d;
            dvs_q    <= dvs_d;
            prem_q   <= prem_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        zdiv_d   = zdiv_q;
        work_d   = work_q;
        dvs_d    = dvs_q;
        prem_d   = prem_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;

        // Partial remainder stays below |divisor| <= 2^(N-1), so the shifted value never reaches 2^N
        // and the top bit of the trial difference is a clean borrow flag.
        shifted = {prem_q, work_q[2*N-1]};
        trial   = shifted - {1'b0, dvs_q};
        dvd_mag = dividend[2*N-1] ? -dividend : dividend;
        dvs_mag = divisor[N-1] ? -divisor : divisor;
        q_sgn   = sign_q_q ? -work_q[N-1:0] : work_q[N-1:0];
        r_sgn   = sign_r_q ? -prem_q[N-1:0] : prem_q[N-1:0];
        q_big   = sign_q_q ? (work_q > LIM_NEG) : (work_q > LIM_POS);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_q_d = dividend[2*N-1] ^ divisor[N-1];
                    sign_r_d = dividend[2*N-1];
                    zdiv_d   = (divisor == '0);
                    work_d   = dvd_mag;
                    dvs_d    = {1'b0, dvs_mag};
                    prem_d   = '0;
                    cnt_d    = '0;
`ifdef BOOTH_DIVIDER_DBZ_FAST_EN
                    state_d  = (divisor == '0) ? S_COMMIT : S_CALC;
`else
                    state_d  = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (trial[N+1]) begin
                    prem_d = shifted[N:0];
                    work_d = {work_q[2*N-2:0], 1'b0};
                end else begin
                    prem_d = trial[N:0];
                    work_d = {work_q[2*N-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(2*N-1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (zdiv_q) begin
                    quo_d = '0;
                    rem_d = '0;
                    ovf_d = 1'b0;
                    dbz_d = 1'b1;
                end else begin
                    rem_d = r_sgn;
                    dbz_d = 1'b0;
                    ovf_d = q_big;
                    if (q_big) begin
                        quo_d = sign_q_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                    end else begin
                        quo_d = q_sgn;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign ovf         = ovf_q;
    assign dbz         = dbz_q;
    assign dbg_state_o = state_q;
endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed divider; the inverse operation to the team's radix-2 Booth multiplier. Takes a 2N-bit signed dividend (a product-width value) and an N-bit signed divisor, and returns an N-bit signed quotient and an N-bit signed remainder.
- Iterative restoring division on magnitudes, one quotient bit per clock, with sign correction at the end.
- Uses the same start/clk handshake as the multiplier, so both blocks can share one datapath controller.

Parameters:
- N, 8, operand width; dividend is 2N bits; quotient and remainder are N bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  2N  signed two's-complement dividend; captured when start is sampled.
- divisor  in  N  signed two's-complement divisor; captured when start is sampled.
- quotient  out  N  signed quotient, truncated toward zero.
- remainder  out  N  signed remainder; same sign as dividend, or zero.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle registered completion pulse.
- ovf  out  1  quotient not representable in N signed bits.
- dbz  out  1  divisor was zero.

Behaviour:
- Reset (async, rst_n=0):
  - state goes to IDLE.
  - quotient, remainder, busy, done, ovf and dbz all go to 0.
  - Internal registers and the counter are cleared.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE -> CALC -> COMMIT -> IDLE.
- IDLE:
  - On a clk edge with start=1: capture sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Load |dividend| into a 2N-bit working register and |divisor| into an (N+1)-bit register. |−2^(N-1)| = 2^(N-1) is held unsigned, with no overflow at this step.
  - Clear the partial remainder (N+1 bits) and the counter; go to CALC.
  - Outputs hold their previous values until COMMIT.
- CALC, one iteration per edge, 2N edges:
  - Shift {partial remainder, working register} left by 1.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - After the 2N-th iteration go to COMMIT.
- COMMIT, single edge:
  - Apply signs: quotient = sign_q ? −Qmag : Qmag; remainder = sign_r ? −Rmag : Rmag.
  - Overflow: if the 2N-bit Qmag exceeds 2^(N-1)−1 for sign_q=0, or exceeds 2^(N-1) for sign_q=1:
    - set ovf=1;
    - saturate quotient to 0x7F (positive) or 0x80 (negative), scaled to N;
    - remainder is still the true remainder (|R| < |divisor| ≤ 2^(N-1), so it always fits).
  - Otherwise ovf=0.
  - Raise done=1 for this cycle and go to IDLE.
- Latency (N=8): start sampled at edge 1; iterations on edges 2..17; outputs and done register at edge 18 (2N+2 edges total).
- busy is high from edge 1 through edge 18. done falls at the next edge.
- Divide by zero:
  - Detected at capture; latency is unchanged.
  - At COMMIT: dbz=1, quotient=0, remainder=0, ovf=0.
- ovf and dbz are valid with done and hold until the next COMMIT.
- start while busy: ignored and not queued. Operand changes while busy have no effect.
- start held high continuously: a new operation begins on the edge after COMMIT, i.e. back-to-back with one IDLE cycle.
- Zero dividend: quotient=0, remainder=0, no flags.

Optional Feature:
- Macro: BOOTH_DIVIDER_DBZ_FAST_EN.
- Defined: on a zero divisor, IDLE goes directly to COMMIT. done and dbz=1 appear at edge 2 after start is sampled, and busy is high for 2 cycles only.
- Undefined: divide by zero takes the full 2N+2 latency as specified above.
- Non-zero divisors behave identically in both builds.

Test Plan:
- dividend=14, divisor=7 -> quotient=2, remainder=0, ovf=0, dbz=0; done exactly 18 edges after start is sampled, busy high throughout.
- dividend=−21, divisor=3 -> quotient=−7 (0xF9), remainder=0; then dividend=−600, divisor=15 -> quotient=−40 (0xD8), remainder=0.
- Sign-of-remainder checks:
  - 100 / −7 -> quotient=−14, remainder=2.
  - −100 / 7 -> quotient=−14, remainder=−2.
  - −128 / −1 -> quotient=128, which overflows: ovf=1, quotient=0x7F.
  - −256 / 2 -> quotient=−128 (0x80), ovf=0.
- Overflow and divide by zero:
  - 1000 / 2 -> ovf=1, quotient=0x7F, remainder=0.
  - 5 / 0 -> dbz=1, quotient=0, remainder=0. Done arrives at edge 18 without the macro, at edge 2 with BOOTH_DIVIDER_DBZ_FAST_EN.
- Busy and reset:
  - Pulse start with new operands at edge 5 of an operation -> ignored; results match the first operands.
  - Assert rst_n=0 at edge 10 -> all outputs 0 immediately with no done pulse; the next start after release gives a correct result.
